// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: write port, scan controls and display outputs of the scan controller
interface seg_scan_ctrl_if;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] dig_en;
    logic [2:0] sel;
    logic [3:0] nibble;
    logic [7:0] an;
    logic       frame_tick;
    modport master (
        output en, wr_en, wr_addr, wr_data, dig_en,
        input  sel, nibble, an, frame_tick
    );
    modport slave (
        input  en, wr_en, wr_addr, wr_data, dig_en,
        output sel, nibble, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-segment scan with a blanking gap between digits
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 100000,
    parameter int BLANK_CYC = 16
) (
    input logic            clk,
    input logic            rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - BLANK_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    typedef enum logic [1:0] {OFF, SHOW, BLANK} state_t;
    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    an_q, an_n;
    logic          ft_q, ft_n;
    logic [3:0]    digit_reg [8];
    // Next slot position and the registered anode/tick values it implies; en=0 always wins
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + 1'b1;
        if (!bus.en) begin
            state_n = OFF;
            idx_n   = '0;
            cnt_n   = '0;
        end else if (state == OFF) begin
            state_n = SHOW;
            cnt_n   = '0;
        end else if (state == SHOW && cnt == SHOW_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            state_n = SHOW;
            cnt_n   = '0;
            idx_n   = idx + 1'b1;
        end
        an_n = (state_n == SHOW) ? ~({7'b0, bus.dig_en[idx_n]} << idx_n) : 8'hFF;
        ft_n = bus.en && state == BLANK && cnt == BLANK_LAST && idx == 3'd7;
    end
    // State, output registers and digit storage; reset discards any same-cycle write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= OFF;
            idx       <= '0;
            cnt       <= '0;
            an_q      <= 8'hFF;
            ft_q      <= 1'b0;
            digit_reg <= '{default: '0};
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            an_q  <= an_n;
            ft_q  <= ft_n;
            if (bus.wr_en) digit_reg[bus.wr_addr] <= bus.wr_data;
        end
    end
    assign bus.sel        = idx;
    assign bus.nibble     = digit_reg[idx];
    assign bus.an         = an_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scenarios checked against a slot-arithmetic display model
module tb_seg_scan_ctrl;
    localparam int CD = 8;
    localparam int BC = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int mk = -1;
    logic [3:0] mem [8];
    logic [7:0] e_an;
    logic [2:0] e_sel;
    logic [3:0] e_nib;
    logic       e_ft;
    seg_scan_ctrl_if b ();
    seg_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYC(BC)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    // Model: mk counts cycles since the scan (re)started; everything follows from mk and mem
    always @(posedge clk) begin
        if (!rst_n) begin
            mk = -1;
            for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        end else begin
            if (b.wr_en) mem[b.wr_addr] = b.wr_data;
            mk = b.en ? mk + 1 : -1;
        end
        if (mk < 0) begin
            e_sel = 3'd0;
            e_an  = 8'hFF;
            e_ft  = 1'b0;
        end else begin
            e_sel = 3'((mk / CD) % 8);
            e_an  = ((mk % CD) < (CD - BC) && b.dig_en[e_sel]) ? ~(8'd1 << e_sel) : 8'hFF;
            e_ft  = (mk > 0 && mk % (8 * CD) == 0);
        end
        e_nib = mem[e_sel];
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        b.en = 1'b1;
        b.wr_en = 1'b1;
        b.wr_addr = 3'($urandom_range(0, 7));
        b.wr_data = 4'hF;
        b.dig_en = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {8'hFF, 3'd0, 4'h0, 1'b0})
                $display("FAIL reset cyc=%0d got an=%h sel=%0d nib=%h ft=%b want an=ff sel=0 nib=0 ft=0",
                         i, b.an, b.sel, b.nibble, b.frame_tick);
            else pass_cnt++;
        end
        rst_n = 1'b1;
        b.wr_en = 1'b0;
        for (int i = 0; i < 8 * CD + 2; i++) begin
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL reset_readback k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
    endtask
    task automatic test_basic_scan;
        int ticks = 0;
        b.en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b.wr_en = 1'b1;
            b.wr_addr = 3'(i);
            b.wr_data = 4'(i);
            tick;
        end
        b.wr_en = 1'b0;
        b.dig_en = 8'hFF;
        b.en = 1'b1;
        tick;
        for (int i = 0; i < 130; i++) begin
            tick;
            ticks += int'(b.frame_tick);
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL basic_scan k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
        total_cnt++;
        if (ticks !== 2) $display("FAIL basic_scan_tick_count got %0d want 2", ticks);
        else pass_cnt++;
    endtask
    task automatic test_live_write;
        int n = 0;
        while (!(mk >= 0 && e_sel == 3'd3 && mk % CD == 1) && n < 200) begin
            tick;
            n++;
        end
        total_cnt++;
        if (!(mk >= 0 && e_sel == 3'd3 && mk % CD == 1)) $display("FAIL live_write_wait got timeout want digit 3 show");
        else pass_cnt++;
        b.wr_en = 1'b1;
        b.wr_addr = 3'd3;
        b.wr_data = 4'hA;
        tick;
        b.wr_en = 1'b0;
        total_cnt++;
        if ({b.nibble, b.an} !== {4'hA, 8'hF7})
            $display("FAIL live_write got nib=%h an=%h want nib=a an=f7", b.nibble, b.an);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL live_write_after k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
    endtask
    task automatic test_dig_mask;
        b.dig_en = 8'b1111_0101;
        for (int i = 0; i < 8 * CD; i++) begin
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL dig_mask k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
        b.dig_en = 8'hFF;
    endtask
    task automatic test_disable;
        int n = 0;
        while (!(mk >= 0 && e_sel == 3'd5 && mk % CD == 2) && n < 200) begin
            tick;
            n++;
        end
        total_cnt++;
        if (!(mk >= 0 && e_sel == 3'd5 && mk % CD == 2)) $display("FAIL disable_wait got timeout want digit 5 show");
        else pass_cnt++;
        b.en = 1'b0;
        tick;
        total_cnt++;
        if ({b.an, b.sel, b.frame_tick} !== {8'hFF, 3'd0, 1'b0})
            $display("FAIL disable got an=%h sel=%0d ft=%b want an=ff sel=0 ft=0", b.an, b.sel, b.frame_tick);
        else pass_cnt++;
        b.en = 1'b1;
        for (int i = 0; i < 8 * CD + 8; i++) begin
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL restart k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
    endtask
    task automatic test_boundary_wrap;
        int n = 0;
        while (!(mk >= 0 && mk % (8 * CD) == 8 * CD - 1) && n < 200) begin
            tick;
            n++;
        end
        total_cnt++;
        if (!(mk >= 0 && mk % (8 * CD) == 8 * CD - 1)) $display("FAIL wrap_wait got timeout want last blank of digit 7");
        else pass_cnt++;
        b.wr_en = 1'b1;
        b.wr_addr = 3'd0;
        b.wr_data = 4'hF;
        tick;
        b.wr_en = 1'b0;
        total_cnt++;
        if ({b.sel, b.nibble, b.frame_tick, b.an} !== {3'd0, 4'hF, 1'b1, 8'hFE})
            $display("FAIL boundary_wrap got sel=%0d nib=%h ft=%b an=%h want sel=0 nib=f ft=1 an=fe",
                     b.sel, b.nibble, b.frame_tick, b.an);
        else pass_cnt++;
    endtask
    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            b.en = ($urandom_range(0, 59) != 0);
            b.wr_en = $urandom_range(0, 3) == 0;
            b.wr_addr = 3'($urandom);
            b.wr_data = 4'($urandom);
            if ($urandom_range(0, 15) == 0) b.dig_en = 8'($urandom);
            tick;
            total_cnt++;
            if ({b.an, b.sel, b.nibble, b.frame_tick} !== {e_an, e_sel, e_nib, e_ft})
                $display("FAIL random k=%0d got an=%h sel=%0d nib=%h ft=%b want an=%h sel=%0d nib=%h ft=%b",
                         mk, b.an, b.sel, b.nibble, b.frame_tick, e_an, e_sel, e_nib, e_ft);
            else pass_cnt++;
        end
        b.wr_en = 1'b0;
    endtask
    initial begin
        b.en = 1'b0;
        b.wr_en = 1'b0;
        b.wr_addr = 3'd0;
        b.wr_data = 4'h0;
        b.dig_en = 8'hFF;
        test_reset;
        test_basic_scan;
        test_live_write;
        test_dig_mask;
        test_disable;
        test_boundary_wrap;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
